mem_datos: RTL and testbench

MEM_DATOS -- requirements
Module: mem_datos

---
 rtl/mem_datos_pkg.sv | 13 +
 rtl/mem_datos_ram.sv | 31 +++
 rtl/mem_datos.sv | 55 +++++
 tb/tb_mem_datos.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/mem_datos_pkg.sv
// Shared constants for the mem_datos data memory: word width, default depth
// and the address-width helper.
package mem_datos_pkg;

    localparam int DATA_W        = 32;
    localparam int DEPTH_DEFAULT = 64;

    // Index width for a given depth; never narrower than one bit.
    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/mem_datos_ram.sv
// Word-addressed storage array: asynchronous read, synchronous write and
// synchronous whole-array clear (clear wins over write).
module mem_datos_ram #(
    parameter int DEPTH  = 64,
    parameter int DATA_W = 32,
    parameter int AW     = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[addr] <= wdata;
        end
    end

    // No write-through: a same-cycle write only becomes visible after the edge.
    assign rdata = mem[addr];

endmodule

// File: rtl/mem_datos.sv
// Data memory top: address decode and optional range check around the RAM.
// Define MEM_DATOS_ERR_EN to add Addr_Err and block out-of-range accesses.
module mem_datos #(
    parameter int DEPTH  = mem_datos_pkg::DEPTH_DEFAULT,
    parameter int DATA_W = mem_datos_pkg::DATA_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] ALUResult,
    input  logic [DATA_W-1:0] WriteData,
    input  logic              Write_EN,
`ifdef MEM_DATOS_ERR_EN
    output logic              Addr_Err,
`endif
    output logic [DATA_W-1:0] Read_Data
);

    import mem_datos_pkg::*;

    localparam int AW = addr_w(DEPTH);

    logic [AW-1:0]     index;
    logic              ram_we;
    logic [DATA_W-1:0] ram_rdata;

    assign index = ALUResult[AW-1:0];

`ifdef MEM_DATOS_ERR_EN
    localparam logic [DATA_W-1:0] DEPTH_LIM = DATA_W'(DEPTH);

    assign Addr_Err  = (ALUResult >= DEPTH_LIM);
    assign ram_we    = Write_EN & ~Addr_Err;
    assign Read_Data = Addr_Err ? '0 : ram_rdata;
`else
    // Upper address bits are deliberately dropped so addresses wrap.
    logic unused_upper;
    assign unused_upper = ^ALUResult[DATA_W-1:AW];
    assign ram_we       = Write_EN;
    assign Read_Data    = ram_rdata;
`endif

    mem_datos_ram #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .AW     (AW)
    ) u_ram (
        .clk   (CLK),
        .rst   (RST),
        .we    (ram_we),
        .addr  (index),
        .wdata (WriteData),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_mem_datos.sv
// Directed self-checking bench for mem_datos (DEPTH=64); covers both the
// wrap-around build and the MEM_DATOS_ERR_EN build.
module tb_mem_datos;

    logic        CLK;
    logic        RST;
    logic [31:0] ALUResult;
    logic [31:0] WriteData;
    logic        Write_EN;
    logic [31:0] Read_Data;
`ifdef MEM_DATOS_ERR_EN
    logic        Addr_Err;
`endif

    int n_tests;
    int n_fail;

    mem_datos #(.DEPTH(64)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .ALUResult (ALUResult),
        .WriteData (WriteData),
        .Write_EN  (Write_EN),
`ifdef MEM_DATOS_ERR_EN
        .Addr_Err  (Addr_Err),
`endif
        .Read_Data (Read_Data)
    );

    // Clock and reset
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drivers: inputs change on the falling edge, outputs sampled 1ns after the rising edge.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data);
        @(negedge CLK);
        ALUResult = addr;
        WriteData = data;
        Write_EN  = 1'b1;
        @(posedge CLK);
        #1;
        Write_EN  = 1'b0;
    endtask

    task automatic do_read(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        ALUResult = addr;
        #1;
        check(tag, Read_Data, exp);
    endtask

    task automatic do_reset(input logic [31:0] addr, input logic [31:0] data, input logic we);
        @(negedge CLK);
        RST       = 1'b1;
        ALUResult = addr;
        WriteData = data;
        Write_EN  = we;
        @(posedge CLK);
        #1;
        RST      = 1'b0;
        Write_EN = 1'b0;
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        RST       = 1'b0;
        ALUResult = '0;
        WriteData = '0;
        Write_EN  = 1'b0;

        // Reset with a pending write: the write must be discarded.
        do_reset(32'd0, 32'h0000_0055, 1'b1);
        do_read("rst_a0", 32'd0, 32'h0);
        do_read("rst_a1", 32'd1, 32'h0);
        do_read("rst_a3", 32'd3, 32'h0);
        do_read("rst_a63", 32'd63, 32'h0);

        // Write 2 at index 1; old value visible before the edge.
        @(negedge CLK);
        ALUResult = 32'd1;
        WriteData = 32'd2;
        Write_EN  = 1'b1;
        #1;
        check("rdw_before_edge", Read_Data, 32'h0);
        @(posedge CLK);
        #1;
        check("rdw_after_edge", Read_Data, 32'd2);
        Write_EN = 1'b0;

        // Write disabled: data input ignored.
        @(negedge CLK);
        WriteData = 32'd1;
        @(posedge CLK);
        #1;
        check("we0_hold", Read_Data, 32'd2);

        do_write(32'd3, 32'd4);
        check("wr_a3", Read_Data, 32'd4);
        do_read("rd_a1", 32'd1, 32'd2);
        do_read("rd_a3", 32'd3, 32'd4);
        do_read("isolate_a0", 32'd0, 32'h0);

        // Full 32-bit word, then reset overrides a concurrent write.
        do_write(32'd5, 32'hDEAD_BEEF);
        check("wr_a5_full", Read_Data, 32'hDEAD_BEEF);
        do_reset(32'd5, 32'd7, 1'b1);
        check("rst_prio_a5", Read_Data, 32'h0);
        do_read("rst_clr_a1", 32'd1, 32'h0);
        do_read("rst_clr_a3", 32'd3, 32'h0);

        // Writes resume on the first edge after reset.
        do_write(32'd5, 32'hA5A5_0001);
        check("resume_a5", Read_Data, 32'hA5A5_0001);

        // Top boundary index.
        do_write(32'd63, 32'h0000_003F);
        check("wr_a63", Read_Data, 32'h0000_003F);
        do_read("isolate_a5", 32'd5, 32'hA5A5_0001);

        // Out-of-range address 65.
        do_write(32'd65, 32'd9);
`ifdef MEM_DATOS_ERR_EN
        do_read("err_rd65", 32'd65, 32'h0);
        check("err_flag65", {31'b0, Addr_Err}, 32'd1);
        do_read("err_a1_kept", 32'd1, 32'h0);
        check("err_flag1", {31'b0, Addr_Err}, 32'd0);
        ALUResult = 32'd64;
        #1;
        check("err_flag64", {31'b0, Addr_Err}, 32'd1);
        ALUResult = 32'd63;
        #1;
        check("err_flag63", {31'b0, Addr_Err}, 32'd0);
`else
        do_read("wrap_a1", 32'd1, 32'd9);
        do_read("wrap_a65", 32'd65, 32'd9);
        do_read("wrap_a127", 32'd127, 32'h0000_003F);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
